// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the decode-stage control unit and register file:
// opcode values, ALUOp encodings and the bundled control word.
package regfile_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // All-zero control word: a NOP that never writes the register file.
  localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};

endpackage

// File: rtl/regfile_ctrl_unit_main_ctrl_decoder.sv
// Main control decoder: maps the 6-bit opcode onto the datapath control word.
// Unrecognised (including X) opcodes fall to the NOP word so RegWrite stays 0.
module main_ctrl_decoder
  import regfile_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Opcode to control-word lookup; every signal starts at 0.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: begin
        ctrl = CTRL_NOP;
      end
    endcase
  end

endmodule

// File: rtl/regfile_ctrl_unit.sv
// Decode-stage block: main control decoder, destination-register mux and a
// 2**ADDR_W x DATA_W register file with two asynchronous read ports and one
// clocked write port. Register 0 is hardwired to zero.
// Optional build macro: WRITE_BYPASS_EN -- forwards write_data to a read port
// whose address matches the register being written in the same cycle.
module regfile_ctrl_unit
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [ADDR_W-1:0] write_register,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrc,
  output logic              MemtoReg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic [1:0]        ALUOp
);

  localparam int REG_N = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  ctrl_t ctrl_s;
  logic  wr_en_s;

  logic [REG_N-1:0][DATA_W-1:0] regs_d;
  logic [REG_N-1:0][DATA_W-1:0] regs_q;

  main_ctrl_decoder u_dec (
    .opcode (opcode),
    .ctrl   (ctrl_s)
  );

  assign RegDst   = ctrl_s.reg_dst;
  assign RegWrite = ctrl_s.reg_write;
  assign ALUSrc   = ctrl_s.alu_src;
  assign MemtoReg = ctrl_s.mem_to_reg;
  assign MemRead  = ctrl_s.mem_read;
  assign MemWrite = ctrl_s.mem_write;
  assign Branch   = ctrl_s.branch;
  assign ALUOp    = ctrl_s.alu_op;

  // Destination select and write qualification (register 0 never written).
  always_comb begin
    if (ctrl_s.reg_dst) begin
      write_register = rd;
    end else begin
      write_register = rt;
    end
    wr_en_s = ctrl_s.reg_write && (write_register != ZERO_ADDR);
  end

  // Next-state of the register array: hold, or update the selected entry.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_s) begin
      regs_d[write_register] = write_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: ZERO_DATA};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Asynchronous read ports; address 0 reads zero in every build.
  always_comb begin
    read_data_1 = regs_q[rs];
    read_data_2 = regs_q[rt];
`ifdef WRITE_BYPASS_EN
    if (wr_en_s && (rs == write_register)) begin
      read_data_1 = write_data;
    end else begin
      read_data_1 = regs_q[rs];
    end
    if (wr_en_s && (rt == write_register)) begin
      read_data_2 = write_data;
    end else begin
      read_data_2 = regs_q[rt];
    end
`endif
    if (rs == ZERO_ADDR) begin
      read_data_1 = ZERO_DATA;
    end else begin
      read_data_1 = read_data_1;
    end
    if (rt == ZERO_ADDR) begin
      read_data_2 = ZERO_DATA;
    end else begin
      read_data_2 = read_data_2;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl_unit.sv
// Self-checking bench for regfile_ctrl_unit: directed cases followed by
// randomized instructions, compared against a behavioural register model.
module tb_regfile_ctrl_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] write_data;
  logic [31:0] read_data_1, read_data_2;
  logic [4:0]  write_register;
  logic        RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mdl [32];

  regfile_ctrl_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .write_data     (write_data),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .write_register (write_register),
    .RegDst         (RegDst),
    .RegWrite       (RegWrite),
    .ALUSrc         (ALUSrc),
    .MemtoReg       (MemtoReg),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .Branch         (Branch),
    .ALUOp          (ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected behaviour, written from the instruction semantics.
  function automatic bit is_r(input logic [5:0] op);    return op == 6'd0;  endfunction
  function automatic bit is_lw(input logic [5:0] op);   return op == 6'd35; endfunction
  function automatic bit is_sw(input logic [5:0] op);   return op == 6'd43; endfunction
  function automatic bit is_beq(input logic [5:0] op);  return op == 6'd4;  endfunction
  function automatic bit is_addi(input logic [5:0] op); return op == 6'd8;  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef WRITE_BYPASS_EN
    if (we && a == wa) return wd;
`endif
    return mdl[a];
  endfunction

  // Apply one instruction: check combinational outputs, clock it, update model.
  task automatic step(input logic [5:0] op, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] a3, input logic [31:0] wd, input logic rst);
    bit          we;
    logic [4:0]  wa;
    logic [1:0]  exp_aluop;
    opcode = op; rs = a1; rt = a2; rd = a3; write_data = wd; reset = rst;
    #1;
    wa = is_r(op) ? a3 : a2;
    we = (is_r(op) || is_lw(op) || is_addi(op)) && (wa != 5'd0);
    exp_aluop = is_r(op) ? 2'b10 : (is_beq(op) ? 2'b01 : 2'b00);
    check_eq("RegDst",   {31'd0, RegDst},   {31'd0, is_r(op)});
    check_eq("RegWrite", {31'd0, RegWrite}, {31'd0, is_r(op) || is_lw(op) || is_addi(op)});
    check_eq("ALUSrc",   {31'd0, ALUSrc},   {31'd0, is_lw(op) || is_sw(op) || is_addi(op)});
    check_eq("MemtoReg", {31'd0, MemtoReg}, {31'd0, is_lw(op)});
    check_eq("MemRead",  {31'd0, MemRead},  {31'd0, is_lw(op)});
    check_eq("MemWrite", {31'd0, MemWrite}, {31'd0, is_sw(op)});
    check_eq("Branch",   {31'd0, Branch},   {31'd0, is_beq(op)});
    check_eq("ALUOp",    {30'd0, ALUOp},    {30'd0, exp_aluop});
    check_eq("write_register", {27'd0, write_register}, {27'd0, wa});
    check_eq("read_data_1", read_data_1, model_read(a1, we, wa, wd));
    check_eq("read_data_2", read_data_2, model_read(a2, we, wa, wd));
    @(posedge clk);
    if (rst) begin
      foreach (mdl[i]) mdl[i] = 32'd0;
    end else if (we) begin
      mdl[wa] = wd;
    end
    #1;
  endtask

  // Read-only probe using a NOP opcode so nothing is written.
  task automatic probe(input logic [4:0] a1, input logic [4:0] a2);
    step(6'b111111, a1, a2, 5'd0, 32'd0, 1'b0);
  endtask

  logic [5:0] op_pool [8];

  initial begin
    foreach (mdl[i]) mdl[i] = 32'd0;
    opcode = 6'b111111; rs = 5'd0; rt = 5'd0; rd = 5'd0; write_data = 32'd0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state: all registers read zero.
    for (int i = 0; i < 32; i += 2) probe(i[4:0], 5'(i + 1));

    // 1: R-type write to rd=1, then read it back.
    step(6'b000000, 5'd0, 5'd3, 5'd1, 32'h0000_0007, 1'b0);
    probe(5'd1, 5'd3);
    check_eq("tp1_reg1", read_data_1, 32'h0000_0007);

    // 2: lw writes rt=5, rd=9 untouched.
    step(6'b100011, 5'd0, 5'd5, 5'd9, 32'hDEAD_BEEF, 1'b0);
    probe(5'd5, 5'd9);
    check_eq("tp2_reg5", read_data_1, 32'hDEAD_BEEF);
    check_eq("tp2_reg9", read_data_2, 32'd0);

    // 3: sw and beq do not write.
    step(6'b101011, 5'd0, 5'd6, 5'd7, 32'h1234_5678, 1'b0);
    step(6'b000100, 5'd0, 5'd7, 5'd6, 32'h1234_5678, 1'b0);
    probe(5'd6, 5'd7);
    check_eq("tp3_reg6", read_data_1, 32'd0);

    // 4: write to register 0 is discarded.
    step(6'b000000, 5'd0, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b0);
    probe(5'd0, 5'd0);
    check_eq("tp4_reg0", read_data_1, 32'd0);

    // 5: fill 1..31, then reset alongside a write.
    for (int i = 1; i < 32; i++) step(6'b001000, 5'd0, i[4:0], 5'd0, i, 1'b0);
    probe(5'd31, 5'd17);
    check_eq("tp5_reg31_filled", read_data_1, 32'd31);
    step(6'b000000, 5'd0, 5'd0, 5'd12, 32'hAAAA_5555, 1'b1);
    for (int i = 0; i < 32; i += 2) probe(i[4:0], 5'(i + 1));

    // 6: same-cycle read/write of register 4.
    step(6'b000000, 5'd0, 5'd0, 5'd4, 32'h0000_0011, 1'b0);
    opcode = 6'b000000; rs = 5'd4; rt = 5'd0; rd = 5'd4; write_data = 32'h0000_0022; #1;
`ifdef WRITE_BYPASS_EN
    check_eq("tp6_rdw_before", read_data_1, 32'h0000_0022);
`else
    check_eq("tp6_rdw_before", read_data_1, 32'h0000_0011);
`endif
    step(6'b000000, 5'd4, 5'd0, 5'd4, 32'h0000_0022, 1'b0);
    probe(5'd4, 5'd0);
    check_eq("tp6_rdw_after", read_data_1, 32'h0000_0022);

    // Randomized instruction stream.
    op_pool[0] = 6'b000000; op_pool[1] = 6'b100011; op_pool[2] = 6'b101011;
    op_pool[3] = 6'b000100; op_pool[4] = 6'b001000; op_pool[5] = 6'b000000;
    op_pool[6] = 6'b001000; op_pool[7] = 6'b100011;
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = op_pool[$urandom_range(0, 7)];
      step(op, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
           ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl_unit.md
Name: regfile_ctrl_unit

Overview:
MIPS decode-stage block: main control decoder plus a 32-entry general-purpose register file.
- Decodes the 6-bit opcode into datapath control signals.
- Selects the destination register (rt or rd) from RegDst.
- Provides two combinational read ports and one clocked write port.
- Sits between instruction fetch/decode and the ALU/memory stages of the single-cycle CPU.

Parameters:
DATA_W, 32, register/data width in bits
ADDR_W, 5, register address width; register count = 2**ADDR_W

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
opcode  input  6  instruction bits [31:26]
rs  input  ADDR_W  read port 1 address (instr [25:21])
rt  input  ADDR_W  read port 2 address, I-type destination (instr [20:16])
rd  input  ADDR_W  R-type destination (instr [15:11])
write_data  input  DATA_W  data written to the selected destination
read_data_1  output  DATA_W  contents of register rs
read_data_2  output  DATA_W  contents of register rt
write_register  output  ADDR_W  selected destination address
RegDst  output  1  1 = destination is rd, 0 = destination is rt
RegWrite  output  1  register write enable
ALUSrc  output  1  1 = ALU operand B is the immediate
MemtoReg  output  1  1 = writeback from memory
MemRead  output  1  data memory read enable
MemWrite  output  1  data memory write enable
Branch  output  1  beq branch
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded

Behaviour:
- Control outputs are purely combinational from opcode. Unlisted signals are 0.
  - 000000 (R-type): RegDst=1, RegWrite=1, ALUOp=10.
  - 100011 (lw): ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
  - 101011 (sw): ALUSrc=1, MemWrite=1, ALUOp=00.
  - 000100 (beq): Branch=1, ALUOp=01.
  - 001000 (addi): ALUSrc=1, RegWrite=1, ALUOp=00.
  - Any other opcode: all outputs 0 (NOP; no register write).
- write_register = RegDst ? rd : rt, combinational.
- Reads are asynchronous:
  - read_data_1 = regs[rs]; read_data_2 = regs[rt].
  - Address 0 always reads 0.
- Write:
  - On the rising clk edge with RegWrite=1 and write_register != 0, regs[write_register] <= write_data.
  - Writes to register 0 are discarded.
  - Written data is visible on the read ports after that edge.
- Read-during-write to the same address in one cycle returns the old value (no bypass) unless WRITE_BYPASS_EN is defined.
- Reset: on a rising edge with reset=1, all registers clear to 0. Reset has priority over a simultaneous write.
  - Control outputs and write_register are unaffected by reset (combinational).
  - Read outputs show 0 after the reset edge.
- Unknown or X opcode must not corrupt the register file: decoder default drives RegWrite=0.

Optional Feature:
- Macro: WRITE_BYPASS_EN.
- When defined: if RegWrite=1, write_register != 0 and the read address equals write_register, the read port returns write_data combinationally in the same cycle.
- When undefined: the read port returns stored register contents only.
- Register 0 still reads 0 in both cases.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - Opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
  - Packed struct typedef ctrl_t bundling the eight control signals.
- One sub-module, main_ctrl_decoder: opcode in, ctrl_t out.
- The register array, destination mux and write logic stay in the top module.

Test Plan:
1. Reset, then opcode=000000, rt=3, rd=1, write_data=0x00000007, one clk edge -> RegDst=1, RegWrite=1, write_register=1, read_data_2 (rt=3)=0; then rs=1 -> read_data_1=0x00000007.
2. opcode=100011, rt=5, rd=9, write_data=0xDEADBEEF, clk edge -> write_register=5, ALUSrc=1, MemtoReg=1, MemRead=1; regs[5]=0xDEADBEEF, regs[9] unchanged (0).
3. opcode=101011 and opcode=000100, write_data=0x12345678, clk edge -> RegWrite=0, no register changes; ALUOp=00 and 01 respectively; MemWrite=1 for sw, Branch=1 for beq.
4. R-type with rd=0, write_data=0xFFFFFFFF, clk edge -> rs=0 reads 0.
5. Load regs 1..31 with their index, then assert reset with RegWrite=1 in the same cycle -> every register reads 0 after the edge.
6. Same-cycle read/write of reg 4 (old 0x11, new 0x22) -> read_data_1=0x11 before the edge without WRITE_BYPASS_EN, 0x22 with it; 0x22 after the edge in both builds.
